// File: rtl/mdu_sched.sv
// mdu_sched -- multi-cycle multiply/divide scheduler holding the HI/LO
// architectural registers. Sits beside the ALU in EX.
//
// A MULT/MULTU/DIV/DIVU issued in IDLE computes its 64-bit result
// immediately and parks it in pend_hi/pend_lo. HI/LO only take it once
// the fixed latency has elapsed. MTHI/MTLO write HI/LO directly when idle.
//
// Ports:
//   clk      in   1   system clock, rising edge
//   reset    in   1   synchronous, active-low reset
//   start    in   1   EX-stage MDU instruction valid
//   op       in   3   0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO, 6/7 no-op
//   a        in  32   rs operand (forwarded)
//   b        in  32   rt operand (forwarded)
//   md_in_d  in   1   MDU-using instruction currently in D
//   busy     out  1   operation in flight
//   stall    out  1   stall request to the hazard unit
//   hi       out 32   HI register
//   lo       out 32   LO register
module mdu_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_in_d,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [0:0]  state;
    logic [3:0]  count;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] div_den;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] smag_q;
    logic [31:0] smag_r;
    logic [31:0] sq;
    logic [31:0] sr;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        is_md_op;

    assign is_md_op = (op <= OP_DIVU);

    // Signed divide runs on magnitudes, then reapplies signs. This gives
    // truncation toward zero, a remainder carrying the dividend's sign, and
    // makes 0x80000000 / -1 fall out naturally as quotient 0x80000000, rem 0.
    always_comb begin
        prod_s  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u  = {32'd0, a} * {32'd0, b};
        div_den = (b == '0) ? 32'd1 : b;
        mag_a   = a[31] ? (32'd0 - a) : a;
        mag_b   = div_den[31] ? (32'd0 - div_den) : div_den;
        smag_q  = mag_a / mag_b;
        smag_r  = mag_a % mag_b;
        sq      = (a[31] ^ div_den[31]) ? (32'd0 - smag_q) : smag_q;
        sr      = a[31] ? (32'd0 - smag_r) : smag_r;
        uq      = a / div_den;
        ur      = a % div_den;

        res_hi = '0;
        res_lo = '0;
        case (op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV: begin
                if (b == '0) begin
                    res_hi = a;
                    res_lo = '1;
                end else begin
                    res_hi = sr;
                    res_lo = sq;
                end
            end
            OP_DIVU: begin
                if (b == '0) begin
                    res_hi = a;
                    res_lo = '1;
                end else begin
                    res_hi = ur;
                    res_lo = uq;
                end
            end
            default: begin
                res_hi = '0;
                res_lo = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            count   <= '0;
            busy    <= 1'b0;
            pend_hi <= '0;
            pend_lo <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (is_md_op) begin
                            pend_hi <= res_hi;
                            pend_lo <= res_lo;
                            count   <= (op == OP_DIV || op == OP_DIVU)
                                       ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                            busy    <= 1'b1;
                            state   <= S_RUN;
                        end else if (op == OP_MTHI) begin
                            hi <= a;
                        end else if (op == OP_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                S_RUN: begin
                    // count==1 here means this edge takes it to zero: commit.
                    if (count == 4'd1) begin
                        hi    <= pend_hi;
                        lo    <= pend_lo;
                        busy  <= 1'b0;
                        count <= '0;
                        state <= S_IDLE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    count <= '0;
                end
            endcase
        end
    end

    // Issue cycle is covered too, so an MDU instruction directly behind a
    // mult/div in EX is held before busy has even risen.
    assign stall = md_in_d & (busy | (start & is_md_op));

endmodule

// File: tb/tb_mdu_sched.sv
module tb_mdu_sched;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_in_d;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    // Behavioural model: remaining latency plus parked result
    int          m_rem = 0;
    logic [31:0] m_hi  = '0;
    logic [31:0] m_lo  = '0;
    logic [31:0] m_phi = '0;
    logic [31:0] m_plo = '0;

    mdu_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .md_in_d(md_in_d), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_result(input logic [2:0] fop,
                                               input logic [31:0] fa,
                                               input logic [31:0] fb);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     r;
        sa = longint'($signed(fa));
        sb = longint'($signed(fb));
        ua = {32'd0, fa};
        ub = {32'd0, fb};
        r  = '0;
        case (fop)
            3'd0: r = sa * sb;
            3'd1: r = ua * ub;
            3'd2: begin
                if (fb == 0) r = {fa, 32'hFFFFFFFF};
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    r  = {sr[31:0], sq[31:0]};
                end
            end
            3'd3: begin
                if (fb == 0) r = {fa, 32'hFFFFFFFF};
                else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    r  = {ur[31:0], uq[31:0]};
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic model_edge();
        logic [63:0] r;
        if (!reset) begin
            m_rem = 0; m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0;
        end else if (m_rem > 0) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (start) begin
            if (op <= 3'd3) begin
                r = ref_result(op, a, b);
                m_phi = r[63:32];
                m_plo = r[31:0];
                m_rem = (op >= 3'd2) ? DC : MC;
            end else if (op == 3'd4) begin
                m_hi = a;
            end else if (op == 3'd5) begin
                m_lo = a;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; md_in_d = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
        total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
        md_in_d = 1'b0;
    endtask

    task automatic test_mult();
        int n;
        start = 1'b1; op = 3'd0; a = 32'hFFFFFFFE; b = 32'd3;
        tick();
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin n++; tick(); end
        total++; if (n != MC) begin bad++; $display("FAIL mult_latency got=%0d exp=%0d", n, MC); end
        total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
        total++; if (lo !== 32'hFFFFFFFA) begin bad++; $display("FAIL mult_lo got=%h exp=fffffffa", lo); end
    endtask

    task automatic test_multu();
        int n;
        logic [31:0] old_hi, old_lo;
        old_hi = hi; old_lo = lo;
        start = 1'b1; op = 3'd1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        tick();
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            total++;
            if (hi !== old_hi || lo !== old_lo) begin
                bad++; $display("FAIL multu_hold got=%h_%h exp=%h_%h", hi, lo, old_hi, old_lo);
            end
            n++; tick();
        end
        total++; if (n != MC) begin bad++; $display("FAIL multu_latency got=%0d exp=%0d", n, MC); end
        total++; if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            bad++; $display("FAIL multu_result got=%h_%h exp=fffffffe_00000001", hi, lo);
        end
    endtask

    task automatic test_div();
        int n;
        start = 1'b1; op = 3'd2; a = 32'hFFFFFFF9; b = 32'd2;
        tick();
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin n++; tick(); end
        total++; if (n != DC) begin bad++; $display("FAIL div_latency got=%0d exp=%0d", n, DC); end
        total++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            bad++; $display("FAIL div_result got=%h_%h exp=ffffffff_fffffffd", hi, lo);
        end
        start = 1'b1; op = 3'd3; a = 32'd7; b = 32'd0;
        tick();
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin n++; tick(); end
        total++; if (n != DC) begin bad++; $display("FAIL divu0_latency got=%0d exp=%0d", n, DC); end
        total++; if (hi !== 32'd7 || lo !== 32'hFFFFFFFF) begin
            bad++; $display("FAIL divu0_result got=%h_%h exp=00000007_ffffffff", hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        md_in_d = 1'b1;
        start = 1'b1; op = 3'd0; a = 32'd100; b = 32'd7;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL stall_issue got=%b exp=1", stall); end
        tick();
        // second issue while busy must be ignored
        start = 1'b1; op = 3'd3; a = 32'd5; b = 32'd2;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            total++; if (stall !== 1'b1) begin bad++; $display("FAIL stall_busy cycle=%0d got=%b exp=1", n, stall); end
            n++; tick();
            start = 1'b0;
        end
        total++; if (n != MC) begin bad++; $display("FAIL b2b_latency got=%0d exp=%0d", n, MC); end
        total++; if (hi !== 32'd0 || lo !== 32'd700) begin
            bad++; $display("FAIL b2b_result got=%h_%h exp=00000000_000002bc", hi, lo);
        end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL stall_after got=%b exp=0", stall); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_no_restart got=%b exp=0", busy); end
        md_in_d = 1'b0;
    endtask

    task automatic test_mthi_div_ovf();
        int n;
        logic [31:0] old_lo;
        old_lo = lo;
        start = 1'b1; op = 3'd4; a = 32'h12345678; b = 32'd0;
        tick();
        start = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mthi_busy got=%b exp=0", busy); end
        total++; if (hi !== 32'h12345678 || lo !== old_lo) begin
            bad++; $display("FAIL mthi_result got=%h_%h exp=12345678_%h", hi, lo, old_lo);
        end
        start = 1'b1; op = 3'd2; a = 32'h80000000; b = 32'hFFFFFFFF;
        tick();
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin n++; tick(); end
        total++; if (n != DC) begin bad++; $display("FAIL ovf_latency got=%0d exp=%0d", n, DC); end
        total++; if (hi !== 32'd0 || lo !== 32'h80000000) begin
            bad++; $display("FAIL ovf_result got=%h_%h exp=00000000_80000000", hi, lo);
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd3;
        tick();
        start = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        total++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            bad++; $display("FAIL midreset got=%b_%h_%h exp=0_00000000_00000000", busy, hi, lo);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            total++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
                bad++; $display("FAIL midreset_ghost cycle=%0d got=%b_%h_%h exp=0_0_0", i, busy, hi, lo);
            end
        end
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic exp_stall;
        for (int i = 0; i < 600; i++) begin
            reset   = ($urandom_range(0, 60) != 0);
            start   = ($urandom_range(0, 2) == 0);
            op      = 3'($urandom_range(0, 7));
            a       = pick_val();
            b       = pick_val();
            md_in_d = $urandom_range(0, 1) != 0;
            #1;
            exp_stall = md_in_d && (m_rem > 0 || (start && op <= 3'd3));
            total++; if (stall !== exp_stall) begin
                bad++; $display("FAIL rnd_stall i=%0d got=%b exp=%b", i, stall, exp_stall);
            end
            tick();
            total++; if (busy !== (m_rem > 0) || hi !== m_hi || lo !== m_lo) begin
                bad++; $display("FAIL rnd_state i=%0d got=%b_%h_%h exp=%b_%h_%h",
                                i, busy, hi, lo, (m_rem > 0), m_hi, m_lo);
            end
        end
        reset = 1'b1; start = 1'b0; md_in_d = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_back_to_back();
        test_mthi_div_ovf();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
